// File: rtl/pipe_hazard_ctrl.sv
// Purpose : IF/ID stall/flush controller. A per-register write scoreboard drives RAW stalls; Flush_Req clears IF/ID for a fixed number of cycles.
// Latency : Stall/Bubble/IF_ID_Clear are combinational in the current cycle; Busy_Mask and Stall_Count are registered (visible after the edge).
// Backpres: Stall holds PC and IF/ID and injects a bubble into ID/EX; a flush overrides a stall and never stalls itself.
//
// Ports:
//   Clk, Reset_n                       rising-edge clock, asynchronous active-low reset
//   ID_Valid, ID_Instruction_Code      instruction in IF/ID ([7:6] opcode, [5:3] rd, [2:0] rs)
//   ID_RegWrite, ID_ALUSrc             rd is written / rs is replaced by an immediate
//   Flush_Req                          single-cycle flush request
//   Stall, IF_ID_Enable                hold PC and IF/ID (IF_ID_Enable = ~Stall)
//   IF_ID_Clear, Bubble                zero IF/ID / zero ID/EX controls at the next edge
//   Busy_Mask                          one bit per register with a pending write
//   Stall_Count                        saturating count of stalled cycles
module pipe_hazard_ctrl #(
    parameter int NUM_REGS   = 8,
    parameter int WB_LATENCY = 2,
    parameter int FLUSH_CYC  = 1,
    parameter int CNT_W      = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                ID_Valid,
    input  logic [7:0]          ID_Instruction_Code,
    input  logic                ID_RegWrite,
    input  logic                ID_ALUSrc,
    input  logic                Flush_Req,
    output logic                Stall,
    output logic                IF_ID_Enable,
    output logic                IF_ID_Clear,
    output logic                Bubble,
    output logic [NUM_REGS-1:0] Busy_Mask,
    output logic [CNT_W-1:0]    Stall_Count
);

    // Scoreboard counters only need to hold WB_LATENCY (at most 3).
    localparam logic [1:0] WB_LOAD    = 2'(WB_LATENCY);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_flush_cnt;
    logic [2:0]          w_flush_cnt_nxt;
    logic [1:0]          r_sb_cnt [NUM_REGS];
    logic [CNT_W-1:0]    r_stall_cnt;

    // ------------------------------------------------------------------
    // Instruction decode and operand-use qualification
    // ------------------------------------------------------------------
    logic [1:0]          w_opc;
    logic [2:0]          w_rd;
    logic [2:0]          w_rs;
    logic                w_rs_read;
    logic                w_rd_read;
    logic                w_rs_busy;
    logic                w_rd_busy;
    logic                w_hazard;

    assign w_opc     = ID_Instruction_Code[7:6];
    assign w_rd      = ID_Instruction_Code[5:3];
    assign w_rs      = ID_Instruction_Code[2:0];

    // An immediate replaces rs; the two-operand ALU op (01) also reads rd.
    assign w_rs_read = ~ID_ALUSrc;
    assign w_rd_read = (w_opc == 2'b01);

    assign w_rs_busy = (r_sb_cnt[w_rs] != 2'd0);
    assign w_rd_busy = (r_sb_cnt[w_rd] != 2'd0);

    assign w_hazard  = ID_Valid & ((w_rs_read & w_rs_busy) | (w_rd_read & w_rd_busy));

    // ------------------------------------------------------------------
    // Control FSM: next state and outputs
    // ------------------------------------------------------------------
    logic                w_stall;
    logic                w_clear;
    logic                w_bubble;
    logic                w_issue;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_stall         = 1'b0;
        w_clear         = 1'b0;
        w_bubble        = 1'b0;
        w_issue         = 1'b0;

        if (Flush_Req) begin
            // Flush beats everything, including a hazard in this same cycle,
            // and restarts the count if a flush is already running.
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
            w_clear         = 1'b1;
            w_bubble        = 1'b1;
        end else begin
            case (r_state)
                ST_RUN, ST_STALL: begin
                    // RUN and STALL share outputs; the state only records
                    // that the held instruction has been waiting.
                    w_stall     = w_hazard;
                    w_bubble    = w_hazard;
                    w_issue     = ID_Valid & ~w_hazard;
                    w_state_nxt = w_hazard ? ST_STALL : ST_RUN;
                end
                ST_FLUSH: begin
                    w_clear  = 1'b1;
                    w_bubble = 1'b1;
                    if (r_flush_cnt <= 3'd1) begin
                        w_state_nxt     = ST_RUN;
                        w_flush_cnt_nxt = 3'd0;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Write scoreboard: load on issue, otherwise count down to zero.
    // A flush does not touch it, so older writes still retire on time.
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] w_load;

    assign w_load = (w_issue & ID_RegWrite) ? (NUM_REGS'(1) << w_rd) : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_sb_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_load[i]) begin
                    r_sb_cnt[i] <= WB_LOAD;
                end else if (r_sb_cnt[i] != 2'd0) begin
                    r_sb_cnt[i] <= r_sb_cnt[i] - 2'd1;
                end
            end
        end
    end

    always_comb begin
        Busy_Mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            Busy_Mask[i] = (r_sb_cnt[i] != 2'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stall performance counter, sticks at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign Stall        = w_stall;
    assign IF_ID_Enable = ~w_stall;
    assign IF_ID_Clear  = w_clear;
    assign Bubble       = w_bubble;
    assign Stall_Count  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl (directed scenarios + random traffic).
// Latency : expectations are pushed by the driver each cycle and popped by the monitor on the falling edge.
// Backpres: the driver holds a stalled instruction in IF/ID until the reference model says it issued.
module tb_pipe_hazard_ctrl;

    localparam int NREG = 8;
    localparam int WB   = 2;
    localparam int FC   = 1;
    localparam int CW   = 4;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic            ID_Valid;
    logic [7:0]      ID_Instruction_Code;
    logic            ID_RegWrite;
    logic            ID_ALUSrc;
    logic            Flush_Req;
    logic            Stall;
    logic            IF_ID_Enable;
    logic            IF_ID_Clear;
    logic            Bubble;
    logic [NREG-1:0] Busy_Mask;
    logic [CW-1:0]   Stall_Count;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl #(
        .NUM_REGS  (NREG),
        .WB_LATENCY(WB),
        .FLUSH_CYC (FC),
        .CNT_W     (CW)
    ) dut (
        .Clk                (Clk),
        .Reset_n            (Reset_n),
        .ID_Valid           (ID_Valid),
        .ID_Instruction_Code(ID_Instruction_Code),
        .ID_RegWrite        (ID_RegWrite),
        .ID_ALUSrc          (ID_ALUSrc),
        .Flush_Req          (Flush_Req),
        .Stall              (Stall),
        .IF_ID_Enable       (IF_ID_Enable),
        .IF_ID_Clear        (IF_ID_Clear),
        .Bubble             (Bubble),
        .Busy_Mask          (Busy_Mask),
        .Stall_Count        (Stall_Count)
    );

    typedef struct {
        logic            stall;
        logic            clr;
        logic            bub;
        logic [NREG-1:0] mask;
        logic [CW-1:0]   cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: a register is busy while the current cycle number is
    // before the cycle at which its pending write becomes readable.
    int   now;
    int   ready_at [NREG];
    int   flush_left;
    int   m_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic bit busy(input int r);
        return now < ready_at[r];
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        flush_left = 0;
        m_cnt      = 0;
    endtask

    // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic v, input logic [7:0] ins, input logic rw,
                        input logic as, input logic fl, output logic stalled);
        exp_t e;
        bit   haz, in_flush, issue;
        int   rs, rd, op;
        ID_Valid            = v;
        ID_Instruction_Code = ins;
        ID_RegWrite         = rw;
        ID_ALUSrc           = as;
        Flush_Req           = fl;
        rs  = int'(ins[2:0]);
        rd  = int'(ins[5:3]);
        op  = int'(ins[7:6]);
        haz = v && ((!as && busy(rs)) || (op == 1 && busy(rd)));
        in_flush = flush_left > 0;
        e.mask = '0;
        for (int r = 0; r < NREG; r++) e.mask[r] = busy(r);
        e.cnt = CW'(m_cnt);
        if (fl || in_flush) begin
            e.stall = 1'b0; e.clr = 1'b1; e.bub = 1'b1;
        end else begin
            e.stall = haz;  e.clr = 1'b0; e.bub = haz;
        end
        sb_q.push_back(e);
        issue = v && !haz && !in_flush && !fl;
        if (issue && rw) ready_at[rd] = now + WB + 1;
        if (fl) flush_left = FC;
        else if (in_flush) flush_left--;
        if (e.stall && m_cnt < (1 << CW) - 1) m_cnt++;
        stalled = e.stall;
        @(posedge Clk); #1;
        now++;
    endtask

    // Asserted away from any clock edge; the monitor checks reset values before the next edge.
    task automatic reset_cycle();
        exp_t e;
        Reset_n             = 1'b0;
        Flush_Req           = 1'b0;
        ID_Valid            = 1'($urandom);
        ID_Instruction_Code = 8'($urandom);
        ID_RegWrite         = 1'($urandom);
        ID_ALUSrc           = 1'($urandom);
        model_clear();
        e.stall = 1'b0; e.clr = 1'b0; e.bub = 1'b0; e.mask = '0; e.cnt = '0;
        sb_q.push_back(e);
        @(posedge Clk); #1;
        now++;
        Reset_n = 1'b1;
    endtask

    // Issue 0x5A (writes r3), then hold 0x43 (reads r3) until it issues.
    task automatic raw_pair();
        logic s;
        int   k;
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, s);
        k = 0;
        do begin
            step(1'b1, 8'h43, 1'b1, 1'b0, 1'b0, s);
            k++;
        end while (s && k < 10);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("stall",       32'(Stall),        32'(e.stall));
                chk("if_id_en",    32'(IF_ID_Enable), 32'(!e.stall));
                chk("if_id_clear", 32'(IF_ID_Clear),  32'(e.clr));
                chk("bubble",      32'(Bubble),       32'(e.bub));
                chk("busy_mask",   32'(Busy_Mask),    32'(e.mask));
                chk("stall_count", 32'(Stall_Count),  32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    initial begin : driver
        logic       s;
        logic       h_v, h_rw, h_as;
        logic [7:0] h_ins;
        Reset_n             = 1'b0;
        ID_Valid            = 1'b0;
        ID_Instruction_Code = 8'h00;
        ID_RegWrite         = 1'b0;
        ID_ALUSrc           = 1'b0;
        Flush_Req           = 1'b0;
        now                 = 0;
        model_clear();
        repeat (2) @(posedge Clk);
        #1;
        reset_cycle();

        // RAW on r3: two stall cycles, then issue.
        raw_pair();
        chk("raw_stall_count", 32'(Stall_Count), 32'd2);

        // Mid-run reset while r0/r3 writes are still pending.
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, s);
        reset_cycle();
        step(1'b1, 8'h43, 1'b1, 1'b0, 1'b0, s);

        // Saturation: ten more RAW pairs give 20 stall cycles on a 4-bit counter.
        for (int i = 0; i < 10; i++) raw_pair();
        chk("sat_stall_count", 32'(Stall_Count), 32'd15);

        // Immediate op behind a write to r0: rs not read, only r3 read.
        step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, s);
        step(1'b1, 8'h58, 1'b1, 1'b1, 1'b0, s);

        // Flush arriving in the second stall cycle.
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, s);
        step(1'b1, 8'h43, 1'b1, 1'b0, 1'b0, s);
        step(1'b1, 8'h43, 1'b1, 1'b0, 1'b1, s);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, s);

        // Back-to-back writes to r1.
        step(1'b1, 8'h08, 1'b1, 1'b1, 1'b0, s);
        step(1'b1, 8'h08, 1'b1, 1'b1, 1'b0, s);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, s);

        // Random traffic; a stalled instruction is held, flushes and resets are sprinkled in.
        s = 1'b0;
        h_v = 1'b0; h_ins = 8'h00; h_rw = 1'b0; h_as = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_cycle();
                s = 1'b0;
            end else begin
                if (!s) begin
                    h_v   = ($urandom_range(0, 99) < 85);
                    h_ins = 8'($urandom);
                    h_rw  = ($urandom_range(0, 99) < 70);
                    h_as  = ($urandom_range(0, 99) < 30);
                end
                step(h_v, h_ins, h_rw, h_as, ($urandom_range(0, 99) < 5), s);
            end
        end

        ID_Valid  = 1'b0;
        Flush_Req = 1'b0;
        @(negedge Clk);
        #1;
        chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
